sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO. Buffers a data stream between a producer and a consumer

---
 rtl/sync_fifo.sv | 99 +++++++++
 tb/tb_sync_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with fill level,
// almost-full backpressure and overflow/underflow pulses.
module sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] FULL_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C =
    (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;

  logic wr_acc, rd_acc;

  assign full        = (cnt_q == FULL_C);
  assign empty       = (cnt_q == '0);
  assign almost_full = (cnt_q >= AF_C);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    wr_err_d   = wr_en & full;
    rd_err_d   = rd_en & empty;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Storage is never cleared; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (n_rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = cnt_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against
// a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       wr_err;
  logic       rd_err;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mq [$];
  logic [7:0] m_rd;
  logic       m_val;
  logic       m_werr;
  logic       m_rerr;

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .wr_err     (wr_err),
    .rd_err     (rd_err)
  );

  // Drive one cycle, advance the model, settle 1ns past the edge.
  task automatic step(input logic rst, input logic we,
                      input logic [7:0] wd, input logic re);
    bit f, e;
    n_rst   = rst;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_rd = '0; m_val = 0; m_werr = 0; m_rerr = 0;
    end else begin
      f = (mq.size() == 16);
      e = (mq.size() == 0);
      m_werr = we && f;
      m_rerr = re && e;
      m_val  = re && !e;
      if (m_val) m_rd = mq.pop_front();
      if (we && !f) mq.push_back(wd);
    end
    #1;
  endtask

  task automatic test_reset;
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    nchk++;
    if (count !== 5'd0) begin
      nerr++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    nchk++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      nerr++;
      $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0",
               empty, full);
    end
    nchk++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rv got v=%b re=%b exp 0 0",
               rd_valid, rd_err);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 8'(i), 0);
      nchk++;
      if (count !== 5'(i + 1)) begin
        nerr++;
        $display("FAIL fill_count got=%0d exp=%0d", count, i + 1);
      end
      nchk++;
      if (almost_full !== (i + 1 >= 12) ||
          full !== (i + 1 == 16)) begin
        nerr++;
        $display("FAIL fill_flags n=%0d got af=%b f=%b",
                 i + 1, almost_full, full);
      end
    end
    step(1, 1, 8'hAA, 0);
    nchk++;
    if (wr_err !== 1'b1 || count !== 5'd16) begin
      nerr++;
      $display("FAIL overflow got werr=%b cnt=%0d exp 1 16",
               wr_err, count);
    end
    step(1, 0, 8'h00, 0);
    nchk++;
    if (wr_err !== 1'b0) begin
      nerr++; $display("FAIL werr_pulse got=%b exp=0", wr_err);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, 1);
      nchk++;
      if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
        nerr++;
        $display("FAIL drain_data got=%h v=%b exp=%h v=1",
                 rd_data, rd_valid, 8'(i));
      end
      nchk++;
      if (count !== 5'(15 - i)) begin
        nerr++;
        $display("FAIL drain_count got=%0d exp=%0d",
                 count, 15 - i);
      end
    end
    nchk++;
    if (empty !== 1'b1) begin
      nerr++; $display("FAIL drain_empty got=%b exp=1", empty);
    end
    step(1, 0, 8'h00, 1);
    nchk++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 ||
        rd_data !== 8'h0F) begin
      nerr++;
      $display("FAIL underflow got re=%b v=%b d=%h exp 1 0 0f",
               rd_err, rd_valid, rd_data);
    end
    step(1, 0, 8'h00, 0);
    nchk++;
    if (rd_err !== 1'b0) begin
      nerr++; $display("FAIL rerr_pulse got=%b exp=0", rd_err);
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 5; i++) step(1, 1, 8'($urandom), 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'($urandom), 1);
      nchk++;
      if (count !== 5'd5 || rd_valid !== 1'b1 ||
          rd_data !== m_rd) begin
        nerr++;
        $display("FAIL simul_mid got c=%0d v=%b d=%h exp 5 1 %h",
                 count, rd_valid, rd_data, m_rd);
      end
    end
    while (mq.size() > 0) step(1, 0, 8'h00, 1);
    step(1, 1, 8'h3C, 1);
    nchk++;
    if (count !== 5'd1 || rd_err !== 1'b1 ||
        rd_valid !== 1'b0) begin
      nerr++;
      $display("FAIL simul_empty got c=%0d re=%b v=%b exp 1 1 0",
               count, rd_err, rd_valid);
    end
    while (mq.size() < 16) step(1, 1, 8'($urandom), 0);
    step(1, 1, 8'hC3, 1);
    nchk++;
    if (count !== 5'd15 || wr_err !== 1'b1 ||
        rd_valid !== 1'b1 || rd_data !== m_rd) begin
      nerr++;
      $display("FAIL simul_full got c=%0d we=%b v=%b d=%h exp %h",
               count, wr_err, rd_valid, rd_data, m_rd);
    end
  endtask

  task automatic test_wrap;
    int  sent = 0;
    int  rcvd = 0;
    int  cyc  = 0;
    bit  we, re, acc;
    while (mq.size() > 0) step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    while (rcvd < 100 && cyc < 3000) begin
      we  = (sent < 100) && ($urandom_range(0, 9) < 6);
      re  = ($urandom_range(0, 9) < 5);
      acc = we && (mq.size() < 16);
      step(1, we, sent[7:0], re);
      if (acc) sent++;
      cyc++;
      nchk++;
      if (count !== 5'(mq.size()) || rd_valid !== m_val) begin
        nerr++;
        $display("FAIL wrap_occ got c=%0d v=%b exp c=%0d v=%b",
                 count, rd_valid, mq.size(), m_val);
      end
      if (m_val) begin
        nchk++;
        if (rd_data !== m_rd || rd_data !== rcvd[7:0]) begin
          nerr++;
          $display("FAIL wrap_data got=%h exp=%h",
                   rd_data, rcvd[7:0]);
        end
        rcvd++;
      end
    end
    nchk++;
    if (rcvd != 100) begin
      nerr++;
      $display("FAIL wrap_timeout got=%0d words exp=100", rcvd);
    end
  endtask

  task automatic test_reset_mid;
    while (mq.size() > 0) step(1, 0, 8'h00, 1);
    for (int i = 0; i < 7; i++) step(1, 1, 8'($urandom), 0);
    nchk++;
    if (count !== 5'd7) begin
      nerr++; $display("FAIL rmid_pre got=%0d exp=7", count);
    end
    step(0, 1, 8'hEE, 1);
    nchk++;
    if (count !== 5'd0 || empty !== 1'b1 ||
        rd_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_clear got c=%0d e=%b v=%b exp 0 1 0",
               count, empty, rd_valid);
    end
    step(1, 1, 8'h55, 0);
    step(1, 0, 8'h00, 1);
    nchk++;
    if (rd_data !== 8'h55 || rd_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_data got=%h v=%b exp=55 v=1",
               rd_data, rd_valid);
    end
  endtask

  initial begin
    n_rst = 0; wr_en = 0; wr_data = '0; rd_en = 0;
    m_rd = '0; m_val = 0; m_werr = 0; m_rerr = 0;
    test_reset;
    test_fill;
    test_drain;
    test_simultaneous;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
